// File: rtl/superscalar_pkg.sv
// Shared MIPS decode helpers for the superscalar front end: opcode/funct
// constants, instruction field positions and the destination-register rule.
package superscalar_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

  // Register written by an instruction; 0 means "writes nothing visible".
  function automatic logic [4:0] dest_reg(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
    logic [4:0] d;
    d = 5'd0;
    case (op)
      OP_RTYPE: d = rd;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI, OP_LW: d = rt;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic is_control(input logic [5:0] op,
                                      input logic [5:0] funct);
    return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
           (op == OP_BNE) || ((op == OP_RTYPE) && (funct == FN_JR));
  endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Fetch-side memory bus plus the IF/ID boundary seen by decode.
interface fetch_issue_queue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data_1;
  logic [31:0] imem_data_2;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] address_1;
  logic [31:0] PC_4;
  logic        valid_1;
  logic [31:0] address_2;
  logic [31:0] PC_8;
  logic        valid_2;

  modport master (
    output imem_addr, address_1, PC_4, valid_1, address_2, PC_8, valid_2,
    input  imem_data_1, imem_data_2, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, address_1, PC_4, valid_1, address_2, PC_8, valid_2,
    output imem_data_1, imem_data_2, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/pair_hazard_check.sv
// Decides whether instr_2 may issue alongside instr_1: no control flow in
// slot 1 and no read-after-write from slot 1 into slot 2.
module pair_hazard_check
  import superscalar_pkg::*;
(
  input  logic [31:0] instr_1,
  input  logic [31:0] instr_2,
  output logic        dual_ok
);

  logic       ctrl_1;
  logic [4:0] dest_1;
  logic       unused_field_bits;

  assign unused_field_bits = ^{instr_1[RS_MSB:RS_LSB], instr_1[10:6],
                               instr_2[OPC_MSB:OPC_LSB], instr_2[RD_MSB:0]};

  always_comb begin
    ctrl_1  = is_control(instr_1[OPC_MSB:OPC_LSB], instr_1[FN_MSB:FN_LSB]);
    dest_1  = dest_reg(instr_1[OPC_MSB:OPC_LSB], instr_1[RT_MSB:RT_LSB],
                       instr_1[RD_MSB:RD_LSB]);
    dual_ok = !ctrl_1 &&
              !((dest_1 != 5'd0) &&
                ((dest_1 == instr_2[RS_MSB:RS_LSB]) ||
                 (dest_1 == instr_2[RT_MSB:RT_LSB])));
  end

endmodule

// File: rtl/fetch_issue_queue.sv
// Dual-issue fetch stage: pair fetch into a circular queue, then issue
// one or two instructions into the registered IF/ID boundary.
module fetch_issue_queue
  import superscalar_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  fetch_issue_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  q_entry_t         queue_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic [31:0] address_1_q;
  logic [31:0] pc_4_q;
  logic        valid_1_q;
  logic [31:0] address_2_q;
  logic [31:0] pc_8_q;
  logic        valid_2_q;

  q_entry_t   head_ent;
  q_entry_t   next_ent;
  logic       dual_ok;
  logic       do_fetch;
  logic [1:0] issue_cnt;
  logic       unused_rpc_bits;

  assign unused_rpc_bits = ^bus.redirect_pc[1:0];

  assign head_p1  = head + PTR_W'(1);
  assign tail_p1  = tail + PTR_W'(1);
  assign head_ent = queue_mem[head];
  assign next_ent = queue_mem[head_p1];
  assign do_fetch = (count <= CNT_W'(DEPTH - 2));

  pair_hazard_check u_hazard (
    .instr_1 (head_ent.instr),
    .instr_2 (next_ent.instr),
    .dual_ok (dual_ok)
  );

  always_comb begin
    issue_cnt = 2'd0;
    if (!bus.stall) begin
      if ((count >= CNT_W'(2)) && dual_ok)
        issue_cnt = 2'd2;
      else if (count != '0)
        issue_cnt = 2'd1;
    end
    count_nxt = count + (do_fetch ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(issue_cnt);
  end

  // fetch stage: queue storage carries data only, so it has no reset
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect && do_fetch) begin
      queue_mem[tail]    <= '{instr: bus.imem_data_1, pc: fetch_pc};
      queue_mem[tail_p1] <= '{instr: bus.imem_data_2, pc: fetch_pc + 32'd4};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (do_fetch) begin
        fetch_pc <= fetch_pc + 32'd8;
        tail     <= tail + PTR_W'(2);
      end
      head  <= head + PTR_W'(issue_cnt);
      count <= count_nxt;
    end
  end

  // issue stage: IF/ID boundary registers
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      address_1_q <= '0;
      pc_4_q      <= '0;
      valid_1_q   <= 1'b0;
      address_2_q <= '0;
      pc_8_q      <= '0;
      valid_2_q   <= 1'b0;
    end else if (!bus.stall) begin
      if (issue_cnt == 2'd0) begin
        address_1_q <= '0;
        pc_4_q      <= '0;
        valid_1_q   <= 1'b0;
        pc_8_q      <= '0;
      end else begin
        address_1_q <= head_ent.instr;
        pc_4_q      <= head_ent.pc + 32'd4;
        valid_1_q   <= 1'b1;
        pc_8_q      <= head_ent.pc + 32'd8;
      end
      address_2_q <= (issue_cnt == 2'd2) ? next_ent.instr : 32'd0;
      valid_2_q   <= (issue_cnt == 2'd2);
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.address_1 = address_1_q;
  assign bus.PC_4      = pc_4_q;
  assign bus.valid_1   = valid_1_q;
  assign bus.address_2 = address_2_q;
  assign bus.PC_8      = pc_8_q;
  assign bus.valid_2   = valid_2_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Bench for fetch_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_issue_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  fetch_issue_queue_if bus ();

  fetch_issue_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [7:0]  rd_idx_2;
  assign rd_idx_2        = bus.imem_addr[9:2] + 8'd1;
  assign bus.imem_data_1 = mem[bus.imem_addr[9:2]];
  assign bus.imem_data_2 = mem[rd_idx_2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q [$];
  logic [31:0] m_fpc, m_a1, m_p4, m_a2, m_p8;
  logic        m_v1, m_v2;

  function automatic bit ref_indep(input logic [31:0] i1, input logic [31:0] i2);
    int op, dst;
    bit ctrl;
    op   = int'(i1[31:26]);
    ctrl = (op inside {2, 3, 4, 5}) || (op == 0 && i1[5:0] == 6'h08);
    dst  = 0;
    if (op == 0) dst = int'(i1[15:11]);
    else if (op inside {8, 9, 10, 12, 13, 14, 15, 35}) dst = int'(i1[20:16]);
    if (ctrl) return 1'b0;
    if (dst != 0 && (dst == int'(i2[25:21]) || dst == int'(i2[20:16]))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear_outs();
    m_a1 = '0; m_p4 = '0; m_v1 = 1'b0; m_a2 = '0; m_p8 = '0; m_v2 = 1'b0;
  endtask

  task automatic model_step();
    int n;
    ent_t e;
    logic [7:0] wi, wi2;
    if (rst) begin
      m_q.delete(); m_fpc = RESET_PC; model_clear_outs();
    end else if (bus.redirect) begin
      m_q.delete(); model_clear_outs(); m_fpc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      n = m_q.size();
      if (!bus.stall) begin
        if (n == 0) model_clear_outs();
        else begin
          m_a1 = m_q[0].instr; m_p4 = m_q[0].pc + 4; m_p8 = m_q[0].pc + 8; m_v1 = 1'b1;
          if (n >= 2 && ref_indep(m_q[0].instr, m_q[1].instr)) begin
            m_a2 = m_q[1].instr; m_v2 = 1'b1;
            void'(m_q.pop_front()); void'(m_q.pop_front());
          end else begin
            m_a2 = '0; m_v2 = 1'b0;
            void'(m_q.pop_front());
          end
        end
      end
      if (n <= DEPTH - 2) begin
        wi = m_fpc[9:2]; wi2 = wi + 8'd1;
        e.instr = mem[wi];  e.pc = m_fpc;     m_q.push_back(e);
        e.instr = mem[wi2]; e.pc = m_fpc + 4; m_q.push_back(e);
        m_fpc = m_fpc + 8;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_at(input logic [31:0] pc);
    bus.redirect = 1'b1; bus.redirect_pc = pc; bus.stall = 1'b0;
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1: return {6'h08, rs, rt, 16'($urandom)};
      2: return {6'h23, rs, rt, 16'($urandom)};
      3: return {6'h04, rs, rt, 16'($urandom)};
      4: return {6'h02, 26'($urandom)};
      5: return {6'h00, rs, 15'd0, 6'h08};
      6: return {6'h2B, rs, rt, 16'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.valid_1 !== 1'b0) begin errors++; $display("FAIL reset_valid_1 got=%b exp=0", bus.valid_1); end
    checks++; if (bus.valid_2 !== 1'b0) begin errors++; $display("FAIL reset_valid_2 got=%b exp=0", bus.valid_2); end
    checks++; if (bus.address_1 !== 32'd0) begin errors++; $display("FAIL reset_address_1 got=%h exp=0", bus.address_1); end
    checks++; if (bus.PC_4 !== 32'd0 || bus.PC_8 !== 32'd0) begin errors++; $display("FAIL reset_pcs got=%h/%h exp=0/0", bus.PC_4, bus.PC_8); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_startup();
    rst = 1'b0;
    tick();
    checks++; if (bus.valid_1 !== 1'b0) begin errors++; $display("FAIL start_edge1_valid got=%b exp=0", bus.valid_1); end
    tick();
    checks++; if (bus.valid_1 !== 1'b1 || bus.valid_2 !== 1'b1) begin errors++; $display("FAIL start_valids got=%b%b exp=11", bus.valid_1, bus.valid_2); end
    checks++; if (bus.address_1 !== mem[0]) begin errors++; $display("FAIL start_address_1 got=%h exp=%h", bus.address_1, mem[0]); end
    checks++; if (bus.address_2 !== mem[1]) begin errors++; $display("FAIL start_address_2 got=%h exp=%h", bus.address_2, mem[1]); end
    checks++; if (bus.PC_4 !== 32'd4 || bus.PC_8 !== 32'd8) begin errors++; $display("FAIL start_pcs got=%h/%h exp=4/8", bus.PC_4, bus.PC_8); end
    tick();
    checks++; if (bus.PC_4 !== 32'd12) begin errors++; $display("FAIL start_next_pc4 got=%h exp=c", bus.PC_4); end
  endtask

  task automatic test_raw();
    start_at(32'h80);
    checks++; if (bus.address_1 !== 32'h00221820 || bus.valid_2 !== 1'b0) begin errors++; $display("FAIL raw_single got=%h v2=%b exp=00221820 v2=0", bus.address_1, bus.valid_2); end
    tick();
    checks++; if (bus.address_1 !== 32'h00642822 || bus.PC_4 !== 32'h88) begin errors++; $display("FAIL raw_second got=%h pc4=%h exp=00642822 pc4=88", bus.address_1, bus.PC_4); end
  endtask

  task automatic test_dest0();
    start_at(32'hA0);
    checks++; if (bus.valid_2 !== 1'b1 || bus.address_2 !== 32'h00042820) begin errors++; $display("FAIL dest0_dual got v2=%b a2=%h exp v2=1 a2=00042820", bus.valid_2, bus.address_2); end
  endtask

  task automatic test_branch();
    start_at(32'hC0);
    checks++; if (bus.address_1 !== 32'h10220003 || bus.valid_2 !== 1'b0) begin errors++; $display("FAIL branch_single got=%h v2=%b exp=10220003 v2=0", bus.address_1, bus.valid_2); end
    tick();
    checks++; if (bus.address_1 !== mem[8'h31] || bus.PC_4 !== 32'hC8) begin errors++; $display("FAIL branch_next got=%h pc4=%h exp=%h pc4=c8", bus.address_1, bus.PC_4, mem[8'h31]); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    start_at(32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'h18) begin errors++; $display("FAIL stall_imem_addr cyc%0d got=%h exp=18", i, bus.imem_addr); end
      checks++; if (bus.address_1 !== mem[0] || bus.PC_4 !== 32'd4 || bus.address_2 !== mem[1] || bus.PC_8 !== 32'd8 || bus.valid_1 !== 1'b1 || bus.valid_2 !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc%0d got a1=%h pc4=%h a2=%h exp a1=%h pc4=4 a2=%h", i, bus.address_1, bus.PC_4, bus.address_2, mem[0], mem[1]);
      end
    end
    checks++; if (dut.count !== 3'(DEPTH)) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", dut.count, DEPTH); end
    bus.stall = 1'b0;
    exp_pc = 32'd8;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.valid_1 !== 1'b1 || bus.PC_4 !== exp_pc + 4 || bus.address_1 !== mem[exp_pc[9:2]]) begin
        errors++; $display("FAIL release_slot1 cyc%0d got pc4=%h a1=%h exp pc4=%h a1=%h", i, bus.PC_4, bus.address_1, exp_pc + 4, mem[exp_pc[9:2]]);
      end
      exp_pc = exp_pc + 4;
      checks++; if (bus.valid_2 !== 1'b1 || bus.address_2 !== mem[exp_pc[9:2]]) begin
        errors++; $display("FAIL release_slot2 cyc%0d got v2=%b a2=%h exp v2=1 a2=%h", i, bus.valid_2, bus.address_2, mem[exp_pc[9:2]]);
      end
      exp_pc = exp_pc + 4;
    end
  endtask

  task automatic test_redirect();
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    tick();
    checks++; if (bus.valid_1 !== 1'b0 || bus.valid_2 !== 1'b0 || bus.address_1 !== 32'd0) begin errors++; $display("FAIL redir_clear got v1=%b v2=%b a1=%h exp 0 0 0", bus.valid_1, bus.valid_2, bus.address_1); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_imem_addr got=%h exp=100", bus.imem_addr); end
    bus.redirect = 1'b0; bus.stall = 1'b0;
    tick(); tick();
    checks++; if (bus.address_1 !== mem[8'h40] || bus.PC_4 !== 32'h104 || bus.valid_1 !== 1'b1) begin errors++; $display("FAIL redir_first got a1=%h pc4=%h exp a1=%h pc4=104", bus.address_1, bus.PC_4, mem[8'h40]); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    checks++; if (bus.valid_1 !== 1'b0 || bus.valid_2 !== 1'b0 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL midrst_state got v1=%b v2=%b addr=%h exp 0 0 %h", bus.valid_1, bus.valid_2, bus.imem_addr, RESET_PC); end
    checks++; if (dut.count !== '0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", dut.count); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.valid_1 !== 1'b1 || bus.PC_4 !== RESET_PC + 4) begin errors++; $display("FAIL midrst_restart got v1=%b pc4=%h exp 1 %h", bus.valid_1, bus.PC_4, RESET_PC + 4); end
  endtask

  task automatic test_random();
    for (int i = 128; i < 256; i++) mem[i] = rand_instr();
    start_at(32'h200);
    for (int c = 0; c < 400; c++) begin
      bus.stall    = ($urandom_range(0, 9) < 3);
      bus.redirect = ($urandom_range(0, 39) == 0);
      bus.redirect_pc = 32'h200 + 32'($urandom_range(0, 511));
      rst          = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (bus.valid_1 !== m_v1 || bus.valid_2 !== m_v2) begin errors++; $display("FAIL rnd_valids cyc%0d got=%b%b exp=%b%b", c, bus.valid_1, bus.valid_2, m_v1, m_v2); end
      checks++; if (bus.address_1 !== m_a1 || bus.PC_4 !== m_p4) begin errors++; $display("FAIL rnd_slot1 cyc%0d got a1=%h pc4=%h exp a1=%h pc4=%h", c, bus.address_1, bus.PC_4, m_a1, m_p4); end
      checks++; if (bus.address_2 !== m_a2 || bus.PC_8 !== m_p8) begin errors++; $display("FAIL rnd_slot2 cyc%0d got a2=%h pc8=%h exp a2=%h pc8=%h", c, bus.address_2, bus.PC_8, m_a2, m_p8); end
      checks++; if (bus.imem_addr !== m_fpc) begin errors++; $display("FAIL rnd_imem_addr cyc%0d got=%h exp=%h", c, bus.imem_addr, m_fpc); end
    end
    bus.stall = 1'b0; bus.redirect = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0022_0020 | (32'(3 + (i % 20)) << 11);
    mem[8'h20] = 32'h00221820;  // add $3,$1,$2
    mem[8'h21] = 32'h00642822;  // sub $5,$3,$4
    mem[8'h28] = 32'h00220020;  // add $0,$1,$2
    mem[8'h29] = 32'h00042820;  // add $5,$0,$4
    mem[8'h30] = 32'h10220003;  // beq $1,$2,3
    test_reset();
    test_startup();
    test_raw();
    test_dest0();
    test_branch();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Dual-issue fetch and issue stage for the superscalar MIPS core, directly upstream of the decode stage. Each cycle it fetches an aligned pair of instruction words from instruction memory into a small circular queue. It then issues zero, one or two instructions into a registered IF/ID boundary that drives decode's `address_1`/`PC_4` and `address_2`/`PC_8` inputs. Slot 2 is issued only when it is independent of slot 1, and it handles downstream stall and branch/jump redirect.

## Interface
- `DEPTH`, 4: queue entries (one instruction word and its PC each); power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_addr`  out  32: fetch address; memory returns words at `imem_addr` and `imem_addr+4` in the same cycle.
- `imem_data_1`  in  32: word at `imem_addr`.
- `imem_data_2`  in  32: word at `imem_addr+4`.
- `stall`  in  1: downstream cannot accept; hold outputs.
- `redirect`  in  1: taken branch/jump; flush and refetch.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are forced to 0.
- `address_1`  out  32: slot-1 instruction word.
- `PC_4`  out  32: slot-1 PC + 4.
- `valid_1`  out  1: slot 1 holds a real instruction.
- `address_2`  out  32: slot-2 instruction word.
- `PC_8`  out  32: slot-1 PC + 8, which is slot-2 PC + 4.
- `valid_2`  out  1: slot 2 holds a real instruction; never 1 while `valid_1` = 0.

## Operation
- State:
  - fetch PC;
  - queue array of {instr, pc};
  - head and tail pointers, wrapping modulo DEPTH;
  - `count`, width $clog2(DEPTH+1);
  - output registers.
- Priority per edge: `rst` > `redirect` > normal.
- Reset:
  - fetch PC = RESET_PC; queue empty (count 0, pointers 0).
  - `address_*`, `PC_4`, `PC_8` = 0; `valid_1` = `valid_2` = 0.
  - `imem_addr` = RESET_PC.
- Redirect (regardless of `stall`):
  - queue flushed;
  - output registers cleared as at reset;
  - fetch PC = {redirect_pc[31:2], 2'b00};
  - no fetch write and no issue that cycle.
- Fetch:
  - Condition: count at cycle start ≤ DEPTH−2.
  - Action: write {imem_data_1, pc} and {imem_data_2, pc+4} at tail; tail += 2; fetch PC += 8.
  - Otherwise the fetch PC holds.
- Issue:
  - Evaluated only when `stall` = 0, using entries present at cycle start.
  - count = 0: outputs cleared, valids 0.
  - count ≥ 1: head entry goes to slot 1 (`PC_4` = pc+4, `PC_8` = pc+8).
  - Head+1 also goes to slot 2 when count ≥ 2 and `dual_ok`; otherwise slot 2 is cleared (`address_2` = 0, `valid_2` = 0).
  - Head advances by the number issued.
- `stall` = 1: output registers and head hold; fetch continues while space remains.
- Count update: count_next = count + 2·fetched − issued. Simultaneous fetch and issue in one cycle is legal.
- `dual_ok` = 0 when either condition holds:
  - slot 1 is control flow: opcode 0x02, 0x03, 0x04 or 0x05, or opcode 0 with funct 0x08;
  - slot 1 destination ≠ 0 and equals slot-2 rs or rt.
- Slot-1 destination:
  - opcode 0 → rd;
  - opcode 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F or 0x23 → rt;
  - otherwise none.
- Ordering: program order is preserved; no instruction is lost or duplicated across stalls.

## Timing
- Fetch-to-issue latency:
  - A pair fetched at edge k is first visible on the outputs after edge k+1.
  - After `rst` deasserts, the first valid output appears after the second edge.
- Throughput: 2 instructions/cycle with independent code and no stall.
- Redirect:
  - Outputs are invalid after the redirect edge.
  - The first redirected instruction is valid two edges later.
- Full queue (count = DEPTH, or DEPTH−1): `imem_addr` holds until issue frees space.
- Reset mid-operation: identical to power-up reset in the next cycle.

## Structure
- `superscalar_pkg` holds:
  - opcode/funct constants (R-type, J, JAL, BEQ, BNE, JR, ADDI…LW);
  - instruction field slice localparams;
  - `dest_reg` function.
- Sub-module `pair_hazard_check` (combinational):
  - inputs: instr_1, instr_2;
  - output: `dual_ok`.
  - Reused by later issue logic.

## Test plan
- Reset, RESET_PC = 0, memory of independent ALU ops:
  - two edges after reset: `valid_1` = `valid_2` = 1, `address_1` = mem[0], `PC_4` = 4, `PC_8` = 8;
  - next cycle: `PC_4` = 12.
- RAW: 0x00221820 (add $3,$1,$2) then 0x00642822 (sub $5,$3,$4):
  - first issue cycle: `valid_2` = 0;
  - next cycle: sub in slot 1 with `PC_4` = sub PC + 4.
- Destination $0: add $0,$1,$2 followed by a reader of $0 → dual issue, `valid_2` = 1.
- beq (0x10220003) in slot 1 → single issue; the next word issues in slot 1 the following cycle.
- Hold `stall` for 4 cycles:
  - outputs constant; count reaches DEPTH; `imem_addr` stops advancing;
  - after release: sequential PCs with no gap or duplicate.
- `redirect` = 1 with `stall` = 1, `redirect_pc` = 0x103:
  - next cycle: valids 0, `imem_addr` = 0x100;
  - two edges later: `address_1` = mem word 0x40, `PC_4` = 0x104.
